// File: rtl/cpu_trace_serializer.sv
// cpu_trace_serializer: turns one structured CPU trace record per handshake
// into the ASCII line format parsed by cpu_checker, one character per clock.
module cpu_trace_serializer #(
    parameter logic [7:0]  IDLE_CHAR = 8'h0A,
    parameter logic [13:0] TIME_MAX  = 14'd9999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_type,
    input  logic [13:0] in_time,
    input  logic [31:0] in_pc,
    input  logic [13:0] in_grf,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_data,
    output logic [7:0]  char,
    output logic        busy,
    output logic [15:0] line_count,
    output logic        clamped
);

    typedef enum logic [4:0] {
        S_IDLE, S_CONV, S_CARET, S_TIME, S_AT, S_PC, S_COLON, S_SP1, S_SIGIL,
        S_GRF, S_ADDR, S_SP2, S_LT, S_EQ, S_SP3, S_DATA, S_HASH, S_NL
    } state_t;

    state_t      state, state_next;
    logic [7:0]  char_next;
    logic        busy_next;
    logic        hash_now;
    logic [2:0]  idx, idx_next;
    logic [3:0]  conv_cnt;
    logic        accept;

    logic        rec_type;
    logic [31:0] pc_r, addr_r, data_r;
    // {bcd[15:0], binary[13:0]} working registers for double-dabble
    logic [29:0] time_sr, grf_sr;
    logic [15:0] time_bcd, grf_bcd;
    logic [13:0] time_clamp, grf_clamp;

    // One double-dabble iteration: add 3 to BCD digits >= 5, then shift left.
    function automatic logic [29:0] dd_step(input logic [29:0] sr);
        logic [29:0] t;
        t = sr;
        for (int unsigned d = 0; d < 4; d++) begin
            if (t[14 + 4*d +: 4] >= 4'd5)
                t[14 + 4*d +: 4] = t[14 + 4*d +: 4] + 4'd3;
        end
        return {t[28:0], 1'b0};
    endfunction

    // Index of the most significant non-zero BCD digit (0 for value zero).
    function automatic logic [2:0] top_idx(input logic [15:0] bcd);
        if (bcd[15:12] != 4'd0)      return 3'd3;
        else if (bcd[11:8] != 4'd0)  return 3'd2;
        else if (bcd[7:4] != 4'd0)   return 3'd1;
        else                         return 3'd0;
    endfunction

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h57 + {4'h0, nib});
    endfunction

    function automatic logic [7:0] dec_char(input logic [3:0] dig);
        return 8'h30 + {4'h0, dig};
    endfunction

    assign in_ready   = (state == S_IDLE);
    assign accept     = in_valid && in_ready;
    assign time_clamp = (in_time > TIME_MAX) ? TIME_MAX : in_time;
    assign grf_clamp  = (in_grf > TIME_MAX) ? TIME_MAX : in_grf;
    assign time_bcd   = time_sr[29:14];
    assign grf_bcd    = grf_sr[29:14];

    // Control state, output character, busy, line counter and sticky clamp flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            char       <= IDLE_CHAR;
            busy       <= 1'b0;
            idx        <= '0;
            line_count <= '0;
            clamped    <= 1'b0;
        end else begin
            state <= state_next;
            char  <= char_next;
            busy  <= busy_next;
            idx   <= idx_next;
            if (hash_now)
                line_count <= line_count + 16'd1;
            if (accept && ((in_time > TIME_MAX) || (in_grf > TIME_MAX)))
                clamped <= 1'b1;
        end
    end

    // Record capture on accept, then 14 parallel double-dabble iterations.
    always_ff @(posedge clk) begin
        if (accept) begin
            rec_type <= in_type;
            pc_r     <= in_pc;
            addr_r   <= in_addr;
            data_r   <= in_data;
            time_sr  <= {16'h0000, time_clamp};
            grf_sr   <= {16'h0000, grf_clamp};
            conv_cnt <= '0;
        end else if (state == S_CONV) begin
            time_sr  <= dd_step(time_sr);
            grf_sr   <= dd_step(grf_sr);
            conv_cnt <= conv_cnt + 4'd1;
        end
    end

    // Next-state and next-character selection for the line being emitted.
    always_comb begin
        state_next = state;
        char_next  = IDLE_CHAR;
        idx_next   = idx;
        busy_next  = busy;
        hash_now   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    state_next = S_CONV;
                    busy_next  = 1'b1;
                end
            end
            S_CONV: begin
                if (conv_cnt == 4'd13)
                    state_next = S_CARET;
            end
            S_CARET: begin
                char_next  = "^";
                idx_next   = top_idx(time_bcd);
                state_next = S_TIME;
            end
            S_TIME: begin
                char_next = dec_char(time_bcd[{idx[1:0], 2'b00} +: 4]);
                if (idx == 3'd0) state_next = S_AT;
                else             idx_next   = idx - 3'd1;
            end
            S_AT: begin
                char_next  = "@";
                idx_next   = 3'd7;
                state_next = S_PC;
            end
            S_PC: begin
                char_next = hex_char(pc_r[{idx, 2'b00} +: 4]);
                if (idx == 3'd0) state_next = S_COLON;
                else             idx_next   = idx - 3'd1;
            end
            S_COLON: begin
                char_next  = ":";
                state_next = S_SP1;
            end
            S_SP1: begin
                char_next  = " ";
                state_next = S_SIGIL;
            end
            S_SIGIL: begin
                char_next  = rec_type ? "*" : "$";
                idx_next   = rec_type ? 3'd7 : top_idx(grf_bcd);
                state_next = rec_type ? S_ADDR : S_GRF;
            end
            S_GRF: begin
                char_next = dec_char(grf_bcd[{idx[1:0], 2'b00} +: 4]);
                if (idx == 3'd0) state_next = S_SP2;
                else             idx_next   = idx - 3'd1;
            end
            S_ADDR: begin
                char_next = hex_char(addr_r[{idx, 2'b00} +: 4]);
                if (idx == 3'd0) state_next = S_SP2;
                else             idx_next   = idx - 3'd1;
            end
            S_SP2: begin
                char_next  = " ";
                state_next = S_LT;
            end
            S_LT: begin
                char_next  = "<";
                state_next = S_EQ;
            end
            S_EQ: begin
                char_next  = "=";
                state_next = S_SP3;
            end
            S_SP3: begin
                char_next  = " ";
                idx_next   = 3'd7;
                state_next = S_DATA;
            end
            S_DATA: begin
                char_next = hex_char(data_r[{idx, 2'b00} +: 4]);
                if (idx == 3'd0) state_next = S_HASH;
                else             idx_next   = idx - 3'd1;
            end
            S_HASH: begin
                char_next  = "#";
                hash_now   = 1'b1;
                state_next = S_NL;
            end
            S_NL: begin
                char_next  = IDLE_CHAR;
                busy_next  = 1'b0;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cpu_trace_serializer.sv
// tb_cpu_trace_serializer: directed records with hand-written expected lines;
// a monitor process checks every emitted character against a scoreboard queue.
module tb_cpu_trace_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_type;
    logic [13:0] in_time;
    logic [31:0] in_pc;
    logic [13:0] in_grf;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  char;
    logic        busy;
    logic [15:0] line_count;
    logic        clamped;

    localparam logic [7:0] IDLE = 8'h0A;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         caret_q[$];
    int         lc_m      = 0;
    bit         clamp_m   = 1'b0;
    bit         ready_bad = 1'b0;
    bit         pend_nl   = 1'b0;
    int         last_caret = 0;
    int         last_len   = 0;

    cpu_trace_serializer #(.IDLE_CHAR(8'h0A), .TIME_MAX(14'd9999)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_type    (in_type),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_grf     (in_grf),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (char),
        .busy       (busy),
        .line_count (line_count),
        .clamped    (clamped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Drive one record (called at a negedge); push its expected line and caret cycle.
    task automatic send(input bit typ, input logic [13:0] t, input logic [31:0] pc,
                        input logic [13:0] grf, input logic [31:0] addr,
                        input logic [31:0] data, input string exp_line,
                        input bit chained, input bit keep_valid, output int k);
        int n;
        int ec;
        in_valid = 1'b1;
        in_type  = typ;
        in_time  = t;
        in_pc    = pc;
        in_grf   = grf;
        in_addr  = addr;
        in_data  = data;
        n = 0;
        while (!in_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        k = cyc;
        if (!in_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        ec = chained ? (last_caret + last_len + 16) : (k + 16);
        for (int i = 0; i < exp_line.len(); i++) exp_q.push_back(exp_line[i]);
        caret_q.push_back(ec);
        last_caret = ec;
        last_len   = exp_line.len();
        if ((t > 14'd9999) || (grf > 14'd9999)) clamp_m = 1'b1;
        @(negedge clk);
        chk("clamped_after_accept", {31'd0, clamped}, {31'd0, clamp_m});
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        if (!keep_valid) in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pend_nl) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);
    endtask

    // Monitor: every non-idle character must be the next scoreboard entry.
    initial begin
        logic [7:0] e;
        int         ec;
        forever begin
            @(negedge clk);
            if (busy && in_ready) ready_bad = 1'b1;
            if (pend_nl) begin
                pend_nl = 1'b0;
                chk("nl_char", {24'd0, char}, {24'd0, IDLE});
                chk("nl_busy", {31'd0, busy}, 32'd0);
                chk("nl_ready", {31'd0, in_ready}, 32'd1);
            end
            if (char !== IDLE) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_char", {24'd0, char}, {24'd0, IDLE});
                end else begin
                    e = exp_q.pop_front();
                    chk("char", {24'd0, char}, {24'd0, e});
                    if (e == "^") begin
                        if (caret_q.size() == 0) begin
                            chk("caret_unexpected", 32'd1, 32'd0);
                        end else begin
                            ec = caret_q.pop_front();
                            chk("caret_cycle", cyc, ec);
                        end
                    end
                    if (e == "#") begin
                        lc_m++;
                        chk("line_count", {16'd0, line_count}, lc_m);
                        chk("ready_low_while_busy", {31'd0, ready_bad}, 32'd0);
                        ready_bad = 1'b0;
                        pend_nl   = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_type  = 1'b0;
        in_time  = '0;
        in_pc    = '0;
        in_grf   = '0;
        in_addr  = '0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        chk("reset_char", {24'd0, char}, {24'd0, IDLE});
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_line_count", {16'd0, line_count}, 32'd0);
        chk("reset_clamped", {31'd0, clamped}, 32'd0);
        chk("reset_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b0;
        @(negedge clk);

        send(1'b0, 14'd5, 32'h00003000, 14'd3, 32'h0, 32'hdeadbeef,
             "^5@00003000: $3 <= deadbeef#", 1'b0, 1'b0, k);
        send(1'b1, 14'd1234, 32'h00004ffc, 14'd0, 32'h0000abcc, 32'h0,
             "^1234@00004ffc: *0000abcc <= 00000000#", 1'b0, 1'b0, k);
        send(1'b0, 14'd0, 32'h0, 14'd0, 32'h0, 32'h1,
             "^0@00000000: $0 <= 00000001#", 1'b0, 1'b0, k);
        send(1'b0, 14'd9999, 32'hffffffff, 14'd9999, 32'h0, 32'h10,
             "^9999@ffffffff: $9999 <= 00000010#", 1'b0, 1'b0, k);
        send(1'b0, 14'd12000, 32'h12345678, 14'd10, 32'h0, 32'ha5a5a5a5,
             "^9999@12345678: $10 <= a5a5a5a5#", 1'b0, 1'b1, k);
        send(1'b1, 14'd42, 32'h0000fedc, 14'd0, 32'hffffffff, 32'h89abcdef,
             "^42@0000fedc: *ffffffff <= 89abcdef#", 1'b1, 1'b0, k);
        drain();
        chk("clamped_sticky", {31'd0, clamped}, 32'd1);
        chk("line_count_six", {16'd0, line_count}, 32'd6);

        send(1'b0, 14'd5, 32'h00003000, 14'd3, 32'h0, 32'hdeadbeef,
             "^5@00003000: $3 <= deadbeef#", 1'b0, 1'b0, k);
        while (cyc < k + 20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        caret_q.delete();
        lc_m    = 0;
        clamp_m = 1'b0;
        chk("abort_char", {24'd0, char}, {24'd0, IDLE});
        chk("abort_line_count", {16'd0, line_count}, 32'd0);
        chk("abort_ready", {31'd0, in_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_clamped", {31'd0, clamped}, 32'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        send(1'b0, 14'd100, 32'h0, 14'd7, 32'h0, 32'h0000cafe,
             "^100@00000000: $7 <= 0000cafe#", 1'b0, 1'b0, k);
        drain();
        chk("final_line_count", {16'd0, line_count}, 32'd1);
        chk("final_caret_queue", caret_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
